// File: rtl/locked_reg_pkg.sv
// Shared types for the locked register write initiator: response codes, FSM states, counter width.
// No logic here beyond a saturating increment helper.
package locked_reg_pkg;

   localparam int DENIED_CNT_W = 8;

   typedef enum logic [1:0] {
      RSP_OK            = 2'b00,
      RSP_LOCKED_DENIED = 2'b01,
      RSP_BAD_ADDR      = 2'b10
   } rsp_status_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ISSUE,
      ST_RESP
   } state_t;

   function automatic logic [DENIED_CNT_W-1:0] sat_inc(input logic [DENIED_CNT_W-1:0] v);
      return (&v) ? v : v + DENIED_CNT_W'(1);
   endfunction

endpackage

// File: rtl/locked_reg_write_initiator_lock_table.sv
// Sticky per-register lock bits set by a one-hot strobe; bit visible the cycle after the strobe.
// Indexed read returns 0 for out-of-range indices; no backpressure.
module lock_table #(
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 4
) (
   input  logic                Clk,
   input  logic                reset,
   input  logic [NUM_REGS-1:0] set,
   input  logic [ADDR_W-1:0]   rd_idx,
   output logic                rd_locked,
   output logic [NUM_REGS-1:0] locked
);

   logic [NUM_REGS-1:0] locked_q;

   always_ff @(posedge Clk) begin
      if (reset) begin
         locked_q <= '0;
      end else begin
         locked_q <= locked_q | set;
      end
   end

   // Loop compare keeps the index width independent of NUM_REGS.
   always_comb begin
      rd_locked = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(rd_idx) == i) begin
            rd_locked = locked_q[i];
         end
      end
   end

   assign locked = locked_q;

endmodule

// File: rtl/locked_reg_write_initiator.sv
// Checks register write/lock requests against the lock table and issues one-cycle strobes.
// Response 3 cycles after the request handshake; req_ready only in IDLE, response held until rsp_ready.
module locked_reg_write_initiator
   import locked_reg_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4
) (
   input  logic                    Clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       req_data,
   input  logic                    req_write,
   input  logic                    req_lock,
   input  logic                    req_trusted,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [1:0]              rsp_status,
   output logic [DATA_W-1:0]       Data_in,
   output logic [NUM_REGS-1:0]     write,
   output logic [NUM_REGS-1:0]     Lock,
   output logic [NUM_REGS-1:0]     lock_status,
   output logic [DENIED_CNT_W-1:0] denied_count
);

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q;
   logic [DATA_W-1:0]       data_q;
   logic                    write_q;
   logic                    lock_q;
   logic                    trusted_q;
   rsp_status_t             status_q, status_d;
   logic [DATA_W-1:0]       data_in_q;
   logic [DENIED_CNT_W-1:0] denied_q;
   logic                    addr_locked;

   lock_table #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_lock_table (
      .Clk       (Clk),
      .reset     (reset),
      .set       (Lock),
      .rd_idx    (addr_q),
      .rd_locked (addr_locked),
      .locked    (lock_status)
   );

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_valid) state_d = ST_CHECK;
         ST_CHECK: state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Decoded outputs are gated by reset so nothing is strobed or offered in the reset cycle.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      write     = '0;
      Lock      = '0;
      if (!reset) begin
         case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_ISSUE: begin
               if (status_q == RSP_OK) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     write[i] = write_q && (int'(addr_q) == i);
                     Lock[i]  = lock_q && (int'(addr_q) == i);
                  end
               end
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      status_d = RSP_OK;
      if (int'(addr_q) >= NUM_REGS) begin
         status_d = RSP_BAD_ADDR;
      end else if (write_q && addr_locked && !trusted_q) begin
         status_d = RSP_LOCKED_DENIED;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         addr_q    <= '0;
         data_q    <= '0;
         write_q   <= 1'b0;
         lock_q    <= 1'b0;
         trusted_q <= 1'b0;
         status_q  <= RSP_OK;
         data_in_q <= '0;
         denied_q  <= '0;
      end else begin
         if (state_q == ST_IDLE && req_valid) begin
            addr_q    <= req_addr;
            data_q    <= req_data;
            write_q   <= req_write;
            lock_q    <= req_lock;
            trusted_q <= req_trusted;
         end
         if (state_q == ST_CHECK) begin
            status_q <= status_d;
            if (status_d == RSP_OK) begin
               data_in_q <= data_q;
            end
         end
         if (state_q == ST_ISSUE && status_q == RSP_LOCKED_DENIED) begin
            denied_q <= sat_inc(denied_q);
         end
      end
   end

   assign rsp_status   = status_q;
   assign Data_in      = data_in_q;
   assign denied_count = denied_q;

endmodule

// File: tb/tb_locked_reg_write_initiator.sv
// Directed bench for locked_reg_write_initiator: lock/deny/bad-address paths, stalls, mid-transaction reset, saturation.
module tb_locked_reg_write_initiator;

   localparam int NUM_REGS = 4;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;

   logic                Clk = 1'b0;
   logic                reset;
   logic                req_valid;
   logic                req_ready;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_data;
   logic                req_write;
   logic                req_lock;
   logic                req_trusted;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [1:0]          rsp_status;
   logic [DATA_W-1:0]   Data_in;
   logic [NUM_REGS-1:0] write;
   logic [NUM_REGS-1:0] Lock;
   logic [NUM_REGS-1:0] lock_status;
   logic [7:0]          denied_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [NUM_REGS-1:0] exp_tbl;
   logic [7:0]          exp_denied;
   logic [DATA_W-1:0]   exp_data_in;

   always #5 Clk = ~Clk;

   locked_reg_write_initiator #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W)
   ) dut (
      .Clk          (Clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_write    (req_write),
      .req_lock     (req_lock),
      .req_trusted  (req_trusted),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_status   (rsp_status),
      .Data_in      (Data_in),
      .write        (write),
      .Lock         (Lock),
      .lock_status  (lock_status),
      .denied_count (denied_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // One full transaction; outputs are sampled on the falling edge of each phase.
   task automatic do_req(input logic [3:0] addr, input logic [15:0] data,
                         input logic wr, input logic lk, input logic tr,
                         input logic [1:0] exp_st, input logic [3:0] exp_wmask,
                         input logic [3:0] exp_lmask, input int hold);
      check_eq("req_ready_idle", req_ready, 1);
      req_valid   = 1'b1;
      req_addr    = addr;
      req_data    = data;
      req_write   = wr;
      req_lock    = lk;
      req_trusted = tr;
      rsp_ready   = 1'b0;
      tick();
      req_valid = 1'b0;
      check_eq("req_ready_check", req_ready, 0);
      check_eq("write_check", write, 0);
      tick();
      if (exp_st == 2'b00) exp_data_in = data;
      check_eq("write_issue", write, exp_wmask);
      check_eq("lock_issue", Lock, exp_lmask);
      check_eq("data_in_issue", Data_in, exp_data_in);
      check_eq("rsp_valid_issue", rsp_valid, 0);
      exp_tbl = exp_tbl | exp_lmask;
      if (exp_st == 2'b01 && exp_denied != 8'd255) exp_denied = exp_denied + 8'd1;
      tick();
      for (int c = 0; c <= hold; c++) begin
         check_eq("rsp_valid_resp", rsp_valid, 1);
         check_eq("rsp_status", rsp_status, exp_st);
         check_eq("req_ready_resp", req_ready, 0);
         check_eq("strobe_resp", {write, Lock}, 0);
         if (c < hold) tick();
      end
      check_eq("lock_status", lock_status, exp_tbl);
      check_eq("denied_count", denied_count, exp_denied);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_eq("rsp_valid_done", rsp_valid, 0);
      check_eq("req_ready_done", req_ready, 1);
   endtask

   // Lock-only request to addr 3 abandoned by a reset in ISSUE or RESP.
   task automatic reset_mid(input bit in_resp);
      req_valid   = 1'b1;
      req_addr    = 4'd3;
      req_data    = 16'h7777;
      req_write   = 1'b0;
      req_lock    = 1'b1;
      req_trusted = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      if (in_resp) begin
         tick();
         check_eq("rst_pre_rsp_valid", rsp_valid, 1);
      end else begin
         check_eq("rst_pre_lock", Lock, 4'b1000);
      end
      reset     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_strobes", {write, Lock}, 0);
      tick();
      check_eq("rst_req_ready_during", req_ready, 0);
      check_eq("rst_rsp_valid_during", rsp_valid, 0);
      reset     = 1'b0;
      rsp_ready = 1'b0;
      #1;
      exp_tbl     = '0;
      exp_denied  = '0;
      exp_data_in = '0;
      check_eq("rst_req_ready_after", req_ready, 1);
      check_eq("rst_rsp_valid_after", rsp_valid, 0);
      check_eq("rst_lock_status", lock_status, 0);
      check_eq("rst_denied", denied_count, 0);
      check_eq("rst_data_in", Data_in, 0);
      tick();
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_data    = '0;
      req_write   = 1'b0;
      req_lock    = 1'b0;
      req_trusted = 1'b0;
      rsp_ready   = 1'b0;
      exp_tbl     = '0;
      exp_denied  = '0;
      exp_data_in = '0;
      @(negedge Clk);
      tick();
      check_eq("reset_req_ready", req_ready, 0);
      check_eq("reset_rsp_valid", rsp_valid, 0);
      check_eq("reset_strobes", {write, Lock}, 0);
      reset = 1'b0;
      #1;
      check_eq("post_reset_req_ready", req_ready, 1);
      check_eq("post_reset_lock_status", lock_status, 0);
      check_eq("post_reset_denied", denied_count, 0);
      check_eq("post_reset_data_in", Data_in, 0);
      tick();

      // addr, data, wr, lk, tr, status, write mask, lock mask, stall cycles
      do_req(4'd2, 16'hA5A5, 1, 0, 0, 2'b00, 4'b0100, 4'b0000, 0);
      do_req(4'd1, 16'h5555, 0, 1, 0, 2'b00, 4'b0000, 4'b0010, 0);
      do_req(4'd1, 16'h1234, 1, 0, 0, 2'b01, 4'b0000, 4'b0000, 0);
      do_req(4'd1, 16'hBEEF, 1, 0, 1, 2'b00, 4'b0010, 4'b0000, 0);
      do_req(4'd1, 16'h0101, 0, 1, 0, 2'b00, 4'b0000, 4'b0010, 0);
      do_req(4'd0, 16'h0F0F, 0, 0, 0, 2'b00, 4'b0000, 4'b0000, 0);
      do_req(4'd3, 16'hC3C3, 1, 1, 0, 2'b00, 4'b1000, 4'b1000, 0);
      do_req(4'd3, 16'h3C3C, 1, 0, 0, 2'b01, 4'b0000, 4'b0000, 0);
      do_req(4'd7, 16'hDEAD, 1, 0, 0, 2'b10, 4'b0000, 4'b0000, 5);
      do_req(4'd4, 16'h4444, 0, 1, 1, 2'b10, 4'b0000, 4'b0000, 0);
      check_eq("lock_table_before_reset", lock_status, 4'b1010);
      check_eq("denied_before_reset", denied_count, 2);

      reset_mid(1'b0);
      do_req(4'd1, 16'h1111, 0, 1, 0, 2'b00, 4'b0000, 4'b0010, 0);
      do_req(4'd1, 16'h2222, 1, 0, 0, 2'b01, 4'b0000, 4'b0000, 0);
      reset_mid(1'b1);

      do_req(4'd0, 16'h0000, 0, 1, 0, 2'b00, 4'b0000, 4'b0001, 0);
      for (int k = 0; k < 260; k++) begin
         do_req(4'd0, 16'(k), 1, 0, 0, 2'b01, 4'b0000, 4'b0000, 0);
      end
      check_eq("denied_saturated", denied_count, 8'd255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/locked_reg_write_initiator.md
# locked_reg_write_initiator

Initiator-side controller for the team's lockable register targets. It accepts register write/lock requests over a valid/ready request channel and checks each one against a mirrored per-register lock table. Permitted requests are issued to the register bank as one-cycle `write`/`Lock` strobes with shared `Data_in`. Every request returns a status on a valid/ready response channel. It sits between the configuration bus bridge and the bank of locked registers.

## Interface
Parameters:
- `NUM_REGS`, 4: number of lockable target registers (1..16)
- `DATA_W`, 16: register data width
- `ADDR_W`, 4: request address width; must satisfy 2^ADDR_W >= NUM_REGS

Ports:
- `Clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when both high
- `req_addr`  in  ADDR_W  target register index
- `req_data`  in  DATA_W  write data
- `req_write`  in  1  perform data write
- `req_lock`  in  1  lock target after this request
- `req_trusted`  in  1  requester is trusted
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when both high
- `rsp_status`  out  2  00 OK, 01 LOCKED_DENIED, 10 BAD_ADDR, 11 reserved (never driven)
- `Data_in`  out  DATA_W  data to register bank
- `write`  out  NUM_REGS  one-hot write strobe
- `Lock`  out  NUM_REGS  one-hot lock strobe
- `lock_status`  out  NUM_REGS  mirrored lock table
- `denied_count`  out  8  saturating count of LOCKED_DENIED responses

## Operation
- FSM states: IDLE, CHECK, ISSUE, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake, capture addr/data/write/lock/trusted and go to CHECK.
- CHECK:
  - Evaluate in priority order:
    - addr >= NUM_REGS -> BAD_ADDR.
    - req_write & lock_status[addr] & ~trusted -> LOCKED_DENIED.
    - Otherwise OK.
  - Go to ISSUE.
- ISSUE (one cycle):
  - If OK: `write[addr]`=req_write and `Lock[addr]`=req_lock, both for exactly this cycle; `Data_in`=captured data.
  - If not OK: no strobes.
  - Set `lock_status[addr]` on the next edge when `Lock` pulses.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1 with status held stable until `rsp_ready`, then return to IDLE.
- Lock semantics:
  - Lock is sticky; only `reset` clears the table.
  - Trusted writes to locked registers succeed and never unlock them.
  - A lock-only request (write=0, lock=1) is always OK for a valid address, trusted or not.
  - Locking an already-locked register is OK, with the `Lock` strobe still issued.
  - write=0, lock=0: OK, no strobes.
- `denied_count`: increments on entering RESP with LOCKED_DENIED; saturates at 255.
- Reset (any state, including mid-transaction): return to IDLE, abandon the pending request with no response, and zero all outputs and the table. `req_ready` is 0 during the reset cycle and 1 on the first cycle after.

## Timing
- Handshake at edge N: CHECK N+1, strobes N+2, `rsp_valid` visible N+3.
- Minimum request-to-request spacing is 4 cycles; `req_ready`=0 outside IDLE.
- `Data_in` holds its last issued value between transactions (0 after reset).
- `write`/`Lock` never assert outside ISSUE and are never multi-hot.
- `lock_status` reflects a new lock in the cycle after the `Lock` strobe, before or with `rsp_valid`.
- `rsp_status` and `rsp_valid` are stable while stalled by `rsp_ready`=0.

## Structure
- Shared package `locked_reg_pkg`:
  - `rsp_status_t` enum (OK, LOCKED_DENIED, BAD_ADDR).
  - FSM state enum.
  - `DENIED_CNT_W`=8.
- One natural sub-module, `lock_table`:
  - NUM_REGS sticky bits, set by the one-hot `Lock` vector, cleared by `reset`.
  - Exposes a read by index.
- FSM, capture registers and counter stay in the top module.

## Test plan
- After reset: untrusted write addr 2, data 0xA5A5 -> `write`=0100 for one cycle, `Data_in`=0xA5A5, status OK at cycle N+3.
- Lock addr 1 (untrusted, lock-only), then untrusted write addr 1, data 0x1234 -> first OK with `lock_status`=0010; second LOCKED_DENIED, no `write` pulse, `denied_count`=1.
- Trusted write addr 1, data 0xBEEF after lock -> OK, `write`=0010, `lock_status` still 0010.
- NUM_REGS=4, addr 7 -> BAD_ADDR, no strobes; hold `rsp_ready`=0 for 5 cycles -> status/valid stable, `req_ready`=0 throughout.
- Assert `reset` in ISSUE and in RESP -> no response emitted, table and counter 0, `req_ready`=1 on the next cycle.
- 260 denied requests -> `denied_count` saturates at 255.
